// File: rtl/ps2_ascii_decoder_pkg.sv
// rtl/ps2_ascii_decoder_pkg.sv - shared scan codes and prefix FSM encodings
package ps2_ascii_decoder_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] KEY_LSHIFT   = 8'h12;
  localparam logic [7:0] KEY_RSHIFT   = 8'h59;
  localparam logic [7:0] KEY_CAPS     = 8'h58;
  localparam logic [7:0] KEY_ENTER    = 8'h5A;
  localparam logic [7:0] KEY_SPACE    = 8'h29;
  localparam logic [7:0] KEY_BKSP     = 8'h66;
  localparam logic [7:0] KEY_TAB      = 8'h0D;
  localparam logic [7:0] KEY_KP_SLASH = 8'h4A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } ps2_state_e;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PREFIX_EXT) || (b == PS2_PREFIX_BRK);
  endfunction

endpackage

// File: rtl/ps2_ascii_decoder_if.sv
// rtl/ps2_ascii_decoder_if.sv - scan byte input and ASCII valid/ready output bundle
interface ps2_ascii_decoder_if;
  logic [7:0] rx_data;
  logic       read_data;
  logic [7:0] ascii_data;
  logic       ascii_valid;
  logic       ascii_ready;

  // master: scan source plus character consumer; slave: the decoder
  modport master (
    output rx_data, read_data, ascii_ready,
    input  ascii_data, ascii_valid
  );

  modport slave (
    input  rx_data, read_data, ascii_ready,
    output ascii_data, ascii_valid
  );
endinterface

// File: rtl/ps2_ascii_decoder_scan_to_ascii.sv
// rtl/ps2_ascii_decoder_scan_to_ascii.sv - combinational set-2 make code to ASCII lookup
module ps2_scan_to_ascii
  import ps2_ascii_decoder_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_ext,
  input  logic       i_upper_letter,
  input  logic       i_shift,
  output logic       o_hit,
  output logic [7:0] o_ascii
);

  logic [7:0] w_lower;
  logic [7:0] w_plain;
  logic [7:0] w_shifted;

  always_comb begin
    w_lower = 8'h00;
    case (i_code)
      8'h1C: w_lower = 8'h61;  8'h32: w_lower = 8'h62;  8'h21: w_lower = 8'h63;
      8'h23: w_lower = 8'h64;  8'h24: w_lower = 8'h65;  8'h2B: w_lower = 8'h66;
      8'h34: w_lower = 8'h67;  8'h33: w_lower = 8'h68;  8'h43: w_lower = 8'h69;
      8'h3B: w_lower = 8'h6A;  8'h42: w_lower = 8'h6B;  8'h4B: w_lower = 8'h6C;
      8'h3A: w_lower = 8'h6D;  8'h31: w_lower = 8'h6E;  8'h44: w_lower = 8'h6F;
      8'h4D: w_lower = 8'h70;  8'h15: w_lower = 8'h71;  8'h2D: w_lower = 8'h72;
      8'h1B: w_lower = 8'h73;  8'h2C: w_lower = 8'h74;  8'h3C: w_lower = 8'h75;
      8'h2A: w_lower = 8'h76;  8'h1D: w_lower = 8'h77;  8'h22: w_lower = 8'h78;
      8'h35: w_lower = 8'h79;  8'h1A: w_lower = 8'h7A;
      default: w_lower = 8'h00;
    endcase
  end

  // Non-letters: {unshifted, shifted} glyph pair; whitespace keys repeat the same code
  always_comb begin
    w_plain   = 8'h00;
    w_shifted = 8'h00;
    case (i_code)
      8'h16: begin w_plain = 8'h31; w_shifted = 8'h21; end
      8'h1E: begin w_plain = 8'h32; w_shifted = 8'h40; end
      8'h26: begin w_plain = 8'h33; w_shifted = 8'h23; end
      8'h25: begin w_plain = 8'h34; w_shifted = 8'h24; end
      8'h2E: begin w_plain = 8'h35; w_shifted = 8'h25; end
      8'h36: begin w_plain = 8'h36; w_shifted = 8'h5E; end
      8'h3D: begin w_plain = 8'h37; w_shifted = 8'h26; end
      8'h3E: begin w_plain = 8'h38; w_shifted = 8'h2A; end
      8'h46: begin w_plain = 8'h39; w_shifted = 8'h28; end
      8'h45: begin w_plain = 8'h30; w_shifted = 8'h29; end
      8'h0E: begin w_plain = 8'h60; w_shifted = 8'h7E; end
      8'h4E: begin w_plain = 8'h2D; w_shifted = 8'h5F; end
      8'h55: begin w_plain = 8'h3D; w_shifted = 8'h2B; end
      8'h54: begin w_plain = 8'h5B; w_shifted = 8'h7B; end
      8'h5B: begin w_plain = 8'h5D; w_shifted = 8'h7D; end
      8'h5D: begin w_plain = 8'h5C; w_shifted = 8'h7C; end
      8'h4C: begin w_plain = 8'h3B; w_shifted = 8'h3A; end
      8'h52: begin w_plain = 8'h27; w_shifted = 8'h22; end
      8'h41: begin w_plain = 8'h2C; w_shifted = 8'h3C; end
      8'h49: begin w_plain = 8'h2E; w_shifted = 8'h3E; end
      KEY_KP_SLASH: begin w_plain = 8'h2F; w_shifted = 8'h3F; end
      KEY_SPACE:    begin w_plain = 8'h20; w_shifted = 8'h20; end
      KEY_ENTER:    begin w_plain = 8'h0D; w_shifted = 8'h0D; end
      KEY_BKSP:     begin w_plain = 8'h08; w_shifted = 8'h08; end
      KEY_TAB:      begin w_plain = 8'h09; w_shifted = 8'h09; end
      default: begin w_plain = 8'h00; w_shifted = 8'h00; end
    endcase
  end

  always_comb begin
    o_hit   = 1'b0;
    o_ascii = 8'h00;
    if (i_ext) begin
      if (i_code == KEY_ENTER) begin
        o_hit   = 1'b1;
        o_ascii = 8'h0D;
      end else if (i_code == KEY_KP_SLASH) begin
        o_hit   = 1'b1;
        o_ascii = 8'h2F;
      end
    end else if (w_lower != 8'h00) begin
      o_hit   = 1'b1;
      o_ascii = i_upper_letter ? (w_lower & 8'hDF) : w_lower;
    end else if (w_plain != 8'h00) begin
      o_hit   = 1'b1;
      o_ascii = i_shift ? w_shifted : w_plain;
    end
  end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// rtl/ps2_ascii_decoder.sv - PS/2 scan byte to ASCII decoder with prefix FSM, modifiers and output FIFO
module ps2_ascii_decoder
  import ps2_ascii_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  ps2_ascii_decoder_if.slave     bus,
  output logic                   shift_active,
  output logic                   caps_active,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  ps2_state_e r_state;
  logic       r_lshift;
  logic       r_rshift;
  logic       r_caps;
  logic       r_caps_held;
  logic       r_char_valid;
  logic [7:0] r_char;
  logic       r_overflow;

  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [COUNT_WIDTH-1:0] r_wr_ptr;
  logic [COUNT_WIDTH-1:0] r_rd_ptr;

  logic [COUNT_WIDTH-1:0] w_count;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push_ok;
  logic                   w_hit;
  logic [7:0]             w_ascii;

  assign shift_active = r_lshift | r_rshift;
  assign caps_active  = r_caps;
  assign overflow     = r_overflow;

  ps2_scan_to_ascii u_xlat (
    .i_code         (bus.rx_data),
    .i_ext          (r_state == ST_EXT),
    .i_upper_letter (shift_active ^ r_caps),
    .i_shift        (shift_active),
    .o_hit          (w_hit),
    .o_ascii        (w_ascii)
  );

  // Prefix FSM and modifier tracking; the translated character lands in a one-deep pipeline register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_lshift     <= 1'b0;
      r_rshift     <= 1'b0;
      r_caps       <= 1'b0;
      r_caps_held  <= 1'b0;
      r_char_valid <= 1'b0;
      r_char       <= 8'h00;
    end else begin
      r_char_valid <= 1'b0;
      if (bus.read_data) begin
        case (r_state)
          ST_IDLE: begin
            if (bus.rx_data == PS2_PREFIX_EXT) begin
              r_state <= ST_EXT;
            end else if (bus.rx_data == PS2_PREFIX_BRK) begin
              r_state <= ST_BRK;
            end else begin
              r_char_valid <= w_hit;
              r_char       <= w_ascii;
              case (bus.rx_data)
                KEY_LSHIFT: r_lshift <= 1'b1;
                KEY_RSHIFT: r_rshift <= 1'b1;
                KEY_CAPS: begin
                  if (!r_caps_held) r_caps <= ~r_caps;
                  r_caps_held <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          ST_EXT: begin
            if (bus.rx_data == PS2_PREFIX_BRK) begin
              r_state <= ST_EXTBRK;
            end else if (bus.rx_data != PS2_PREFIX_EXT) begin
              r_char_valid <= w_hit;
              r_char       <= w_ascii;
              r_state      <= ST_IDLE;
            end
          end
          ST_BRK: begin
            if (!is_prefix(bus.rx_data)) begin
              case (bus.rx_data)
                KEY_LSHIFT: r_lshift    <= 1'b0;
                KEY_RSHIFT: r_rshift    <= 1'b0;
                KEY_CAPS:   r_caps_held <= 1'b0;
                default: ;
              endcase
              r_state <= ST_IDLE;
            end
          end
          ST_EXTBRK: begin
            if (!is_prefix(bus.rx_data)) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Pointers carry one extra bit so full and empty are distinguishable
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (w_count == COUNT_WIDTH'(FIFO_DEPTH));
  assign w_pop      = !w_empty && bus.ascii_ready;
  assign w_push_ok  = r_char_valid && (!w_full || w_pop);

  assign fifo_count      = w_count;
  assign bus.ascii_valid = !w_empty;
  assign bus.ascii_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_char_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= r_char;
  end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// tb/tb_ps2_ascii_decoder.sv - scoreboard bench: directed scan sequences, monitor pops and compares
module tb_ps2_ascii_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       shift_active;
  logic       caps_active;
  logic       overflow;
  logic [3:0] fifo_count;

  ps2_ascii_decoder_if bus ();

  ps2_ascii_decoder #(.FIFO_DEPTH(8), .COUNT_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .shift_active (shift_active),
    .caps_active  (caps_active),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data   = b;
    bus.read_data = 1'b1;
    @(posedge clk); #1;
    bus.read_data = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.ascii_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.ascii_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Monitor: every handshake pops one expected character
  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.ascii_valid && bus.ascii_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_char: got %0h expected none", bus.ascii_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("char", bus.ascii_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data     = 8'h00;
    bus.read_data   = 1'b0;
    bus.ascii_ready = 1'b0;
    idle(2);
    check("rst_valid", bus.ascii_valid, 0);
    check("rst_data", bus.ascii_data, 8'h00);
    check("rst_count", fifo_count, 0);
    check("rst_shift", shift_active, 0);
    check("rst_caps", caps_active, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b1;

    // 1: make/break 'a'; valid appears two edges after the strobe
    exp_q.push_back(8'h61);
    send(8'h1C);
    check("t1_valid_e0", bus.ascii_valid, 0);
    idle(1);
    check("t1_valid_e1", bus.ascii_valid, 1);
    check("t1_head", bus.ascii_data, 8'h61);
    check("t1_count", fifo_count, 1);
    send(8'hF0); send(8'h1C);
    drain();

    // 2: shift held around a letter
    send(8'h12);
    check("t2_shift_on", shift_active, 1);
    exp_q.push_back(8'h41); send(8'h1C);
    send(8'hF0); send(8'h12);
    check("t2_shift_off", shift_active, 0);
    exp_q.push_back(8'h61); send(8'h1C);
    drain();

    // 3: caps lock with typematic repeat, caps^shift, digits ignore caps
    send(8'h58); send(8'h58);
    check("t3_caps_on", caps_active, 1);
    send(8'hF0); send(8'h58);
    check("t3_caps_kept", caps_active, 1);
    exp_q.push_back(8'h41); send(8'h1C);
    send(8'h12);
    exp_q.push_back(8'h7A); send(8'h1A);
    send(8'hF0); send(8'h12);
    exp_q.push_back(8'h31); send(8'h16);
    send(8'h58); send(8'hF0); send(8'h58);
    check("t3_caps_off", caps_active, 0);
    drain();

    // Right shift punctuation, whitespace codes, unmapped code
    send(8'h59);
    check("rshift_on", shift_active, 1);
    exp_q.push_back(8'h21); send(8'h16);
    exp_q.push_back(8'h5F); send(8'h4E);
    send(8'hF0); send(8'h59);
    exp_q.push_back(8'h2F); send(8'h4A);
    exp_q.push_back(8'h20); send(8'h29);
    exp_q.push_back(8'h08); send(8'h66);
    exp_q.push_back(8'h09); send(8'h0D);
    exp_q.push_back(8'h0D); send(8'h5A);
    send(8'h76);
    exp_q.push_back(8'h6B); send(8'h42);
    exp_q.push_back(8'h6B); send(8'h42);
    drain();

    // 4: overflow with consumer stalled
    bus.ascii_ready = 1'b0;
    begin
      logic [7:0] codes [9];
      logic [7:0] chars [9];
      codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
      chars = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
      for (int i = 0; i < 9; i++) begin
        if (i < 8) exp_q.push_back(chars[i]);
        send(codes[i]);
      end
    end
    idle(2);
    check("t4_count", fifo_count, 8);
    check("t4_ovf", overflow, 1);
    drain();
    check("t4_ovf_sticky", overflow, 1);
    do_reset();
    check("t4_ovf_rst", overflow, 0);

    // 5: full FIFO, push and pop in the same cycle
    bus.ascii_ready = 1'b0;
    begin
      logic [7:0] dcodes [8];
      dcodes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(8'h31 + 8'(i));
        send(dcodes[i]);
      end
    end
    idle(2);
    check("t5_full", fifo_count, 8);
    @(posedge clk); #1;
    exp_q.push_back(8'h39);
    bus.rx_data   = 8'h46;
    bus.read_data = 1'b1;
    @(posedge clk); #1;
    bus.read_data   = 1'b0;
    bus.ascii_ready = 1'b1;
    @(posedge clk); #1;
    bus.ascii_ready = 1'b0;
    check("t5_count", fifo_count, 8);
    check("t5_ovf", overflow, 0);
    check("t5_head", bus.ascii_data, 8'h32);
    drain();
    check("t5_ovf_end", overflow, 0);

    // 6: extended codes, then reset discards a pending break prefix
    send(8'hE0); send(8'h75);
    idle(3);
    check("t6_ext_none", fifo_count, 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    exp_q.push_back(8'h0D); send(8'hE0); send(8'h5A);
    exp_q.push_back(8'h2F); send(8'hE0); send(8'h4A);
    drain();
    send(8'hF0);
    do_reset();
    exp_q.push_back(8'h61); send(8'h1C);
    drain();
    check("t6_empty", bus.ascii_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
